soc1_ram_test_master: RTL and testbench

- Avalon-MM master that drives the on-chip RAM slave (32-bit data, 4 byte-enables, fixed read latency) from the initiator side.
- One run writes a seeded pattern across a word range, then reads the range back and compares it against the pattern.
- Reports busy, done, error count and the first failing address to a CSR/PIO wrapper or bring-up logic.
- Sits in the SoC1 system beside the CPU data master and is arbitrated by the interconnect.

---
 rtl/soc1_ram_test_pkg.sv | 27 ++
 rtl/soc1_ram_test_master_if.sv | 24 ++
 rtl/soc1_ram_test_cmp.sv | 54 +++++
 rtl/soc1_ram_test_master.sv | 186 ++++++++++++++++++
 tb/tb_soc1_ram_test_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/soc1_ram_test_pkg.sv
// Shared state encoding and pattern generator for the SoC1 RAM test master.
// Build with SOC1_RAM_TEST_INVERT_PASS_EN to add the inverted-data second pass.
package soc1_ram_test_pkg;

  localparam logic [31:0] PAT_K = 32'h9E3779B1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FIN
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
    , ST_WR2
    , ST_RD2
`endif
  } state_t;

  // Multiplicative hash of the word index keeps neighbouring words uncorrelated.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] idx,
                                      input logic inv);
    logic [31:0] p;
    p = seed ^ (idx * PAT_K);
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/soc1_ram_test_master_if.sv
// Avalon-MM bus between the RAM test master and the on-chip RAM slave.
interface soc1_ram_test_master_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/soc1_ram_test_cmp.sv
// Read-back checker: fixed-latency data capture, compare, saturating error count
// and first-failure address capture.
module soc1_ram_test_cmp #(
  parameter int ADDR_W       = 32,
  parameter int ERR_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [31:0]       rdata,
  input  logic [31:0]       exp_data,
  input  logic [ADDR_W-1:0] addr,
  output logic              cmp_vld,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_seen,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [2:0] lat_cnt;
  logic       mismatch;

  // Counter holds READ_LATENCY on the cycle after acceptance, so data is due when it reads 1.
  assign cmp_vld  = (lat_cnt == 3'd1);
  assign mismatch = cmp_vld && (rdata != exp_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= 3'd0;
    end else if (load) begin
      lat_cnt <= 3'(READ_LATENCY);
    end else if (lat_cnt != 3'd0) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count      <= '0;
      err_seen       <= 1'b0;
      first_err_addr <= '0;
    end else if (clear) begin
      err_count      <= '0;
      err_seen       <= 1'b0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
      err_seen <= 1'b1;
      if (!err_seen) first_err_addr <= addr;
    end
  end

endmodule

// File: rtl/soc1_ram_test_master.sv
// SoC1 RAM test master: writes a seeded pattern over a word range, reads it back
// and reports mismatches. SOC1_RAM_TEST_INVERT_PASS_EN adds an inverted-data pass.
module soc1_ram_test_master
  import soc1_ram_test_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 13,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [LEN_W-1:0]       num_words,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_W-1:0]       err_count,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic                   err_seen,
  soc1_ram_test_master_if.master avm
);

  state_t            state;
  state_t            rd_st;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_n;
  logic [LEN_W-1:0]  nwords_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_al;
  logic [31:0]       seed_q;
  logic [31:0]       exp_data;
  logic              inv;
  logic              last;
  logic              start_acc;
  logic              rd_acc;
  logic              cmp_vld;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [LEN_W-1:0] k);
    return b + (ADDR_W'(k) << 2);
  endfunction

  assign base_al   = base_addr & ~ADDR_W'(3);
  assign idx_n     = idx + LEN_W'(1);
  assign last      = (idx == nwords_q - LEN_W'(1));
  assign start_acc = (state == ST_IDLE) && start;
  assign rd_acc    = avm.avm_read && !avm.avm_waitrequest;
  assign exp_data  = pat(seed_q, 32'(idx), inv);

  assign avm.avm_byteenable = 4'hF;

`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
  assign rd_st = inv ? ST_RD2 : ST_RD_REQ;
`else
  assign inv   = 1'b0;
  assign rd_st = ST_RD_REQ;
`endif

  // Run configuration is captured once per start and needs no reset.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      base_q   <= base_al;
      nwords_q <= num_words;
      seed_q   <= seed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
      inv               <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= '0;
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
            inv <= 1'b0;
`endif
            if (num_words == '0) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              busy              <= 1'b1;
              avm.avm_write     <= 1'b1;
              avm.avm_address   <= base_al;
              avm.avm_writedata <= pat(seed, 32'd0, 1'b0);
              state             <= ST_WR;
            end
          end
        end
        ST_WR
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
        , ST_WR2
`endif
        : begin
          if (!avm.avm_waitrequest) begin
            if (last) begin
              idx             <= '0;
              avm.avm_write   <= 1'b0;
              avm.avm_read    <= 1'b1;
              avm.avm_address <= base_q;
              state           <= rd_st;
            end else begin
              idx               <= idx_n;
              avm.avm_address   <= word_addr(base_q, idx_n);
              avm.avm_writedata <= pat(seed_q, 32'(idx_n), inv);
            end
          end
        end
        ST_RD_REQ
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
        , ST_RD2
`endif
        : begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            state        <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cmp_vld) begin
            if (!last) begin
              idx             <= idx_n;
              avm.avm_address <= word_addr(base_q, idx_n);
              avm.avm_read    <= 1'b1;
              state           <= rd_st;
            end
`ifdef SOC1_RAM_TEST_INVERT_PASS_EN
            else if (!inv) begin
              inv               <= 1'b1;
              idx               <= '0;
              avm.avm_write     <= 1'b1;
              avm.avm_address   <= base_q;
              avm.avm_writedata <= pat(seed_q, 32'd0, 1'b1);
              state             <= ST_WR2;
            end
`endif
            else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  soc1_ram_test_cmp #(
    .ADDR_W       (ADDR_W),
    .ERR_W        (ERR_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clear          (start_acc),
    .load           (rd_acc),
    .rdata          (avm.avm_readdata),
    .exp_data       (exp_data),
    .addr           (avm.avm_address),
    .cmp_vld        (cmp_vld),
    .err_count      (err_count),
    .err_seen       (err_seen),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_soc1_ram_test_master.sv
// Directed bench: two masters (read latency 1 and 3) share stimulus, each with its own RAM model.
module tb_soc1_ram_test_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        run_go = 1'b0;
  logic [31:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic [31:0] seed = '0;

  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  eseen;
  logic [15:0] errc [2];
  logic [31:0] ferr [2];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          s_cyc = 0;
  int          corrupt_word = -1;
  int          wr_stall = -1;
  int          rd_stall = -1;
  logic [31:0] cur_base = '0;
  logic [31:0] cur_seed = '0;
  int          w0, w1, r0, r1, d0, d1, b0, b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] tpat(input logic [31:0] s, input int i);
    return s ^ (32'(i) * 32'h9E3779B1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;
    soc1_ram_test_master_if #(.ADDR_W(32)) bus ();
    soc1_ram_test_master #(
      .ADDR_W(32), .LEN_W(13), .READ_LATENCY(LAT), .ERR_W(16)
    ) dut (
      .clk(clk), .reset(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words), .seed(seed), .busy(busy[g]), .done(done[g]),
      .err_count(errc[g]), .first_err_addr(ferr[g]), .err_seen(eseen[g]), .avm(bus)
    );

    logic [31:0] mem [1024];
    logic [31:0] dl [4];
    int wi = 0, ri = 0, wst = 0, rsc = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, wr_last = 0;

    assign bus.avm_waitrequest = (bus.avm_write && (wi == wr_stall) && (wst < 3)) ||
                                 (bus.avm_read && (ri == rd_stall) && (rsc < 3));
    assign bus.avm_readdata = dl[LAT-1];

    // RAM slave model: data appears exactly LAT cycles after acceptance, garbage otherwise.
    always @(posedge clk) begin
      if (run_go) begin
        wi <= 0; ri <= 0; wst <= 0; rsc <= 0;
      end else begin
        if (bus.avm_write && !bus.avm_waitrequest) begin
          mem[bus.avm_address[11:2]] <= bus.avm_writedata;
          wi <= wi + 1;
        end
        if (bus.avm_write && bus.avm_waitrequest) wst <= wst + 1;
        if (bus.avm_read && bus.avm_waitrequest) rsc <= rsc + 1;
        if (bus.avm_read && !bus.avm_waitrequest) ri <= ri + 1;
      end
      dl[0] <= (bus.avm_read && !bus.avm_waitrequest) ?
               (mem[bus.avm_address[11:2]] ^ ((ri == corrupt_word) ? 32'h1 : 32'h0)) :
               32'hDEADBEEF;
      for (int j = 1; j < 4; j++) dl[j] <= dl[j-1];
    end

    always @(negedge clk) begin
      if (busy[g]) busy_cnt <= busy_cnt + 1;
      if (done[g]) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.avm_write) begin
        chk("wr_addr", bus.avm_address, cur_base + 32'(wi) * 32'd4);
        chk("wr_data", bus.avm_writedata, tpat(cur_seed, wi));
        if (!bus.avm_waitrequest) begin
          wr_cnt  <= wr_cnt + 1;
          wr_last <= cyc;
        end
      end
      if (bus.avm_read) begin
        chk("rd_addr", bus.avm_address, cur_base + 32'(ri) * 32'd4);
        if (!bus.avm_waitrequest) rd_cnt <= rd_cnt + 1;
      end
      if (bus.avm_read || bus.avm_write)
        chk("rw_excl", 32'(bus.avm_read & bus.avm_write), 32'd0);
    end
  end

  task automatic launch(input logic [31:0] b, input logic [12:0] n, input logic [31:0] sd);
    @(negedge clk);
    cur_base  = b & ~32'h3;
    cur_seed  = sd;
    base_addr = b;
    num_words = n;
    seed      = sd;
    start     = 1'b1;
    run_go    = 1'b1;
    s_cyc     = cyc;
    w0 = u[0].wr_cnt; w1 = u[1].wr_cnt; r0 = u[0].rd_cnt; r1 = u[1].rd_cnt;
    d0 = u[0].done_cnt; d1 = u[1].done_cnt; b0 = u[0].busy_cnt; b1 = u[1].busy_cnt;
    @(negedge clk);
    start  = 1'b0;
    run_go = 1'b0;
  endtask

  task automatic pulse_ignored_start(input logic [31:0] b, input logic [12:0] n,
                                     input logic [31:0] sd);
    base_addr = b;
    num_words = n;
    seed      = sd;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish(input int n, input int lat0, input int lat1);
    int k;
    k = 0;
    while ((u[0].done_cnt == d0 || u[1].done_cnt == d1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(k < 400), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_lat0", u[0].done_cyc - s_cyc, lat0);
    chk("done_lat1", u[1].done_cyc - s_cyc, lat1);
    chk("done_once0", u[0].done_cnt - d0, 1);
    chk("done_once1", u[1].done_cnt - d1, 1);
    chk("wr_count0", u[0].wr_cnt - w0, n);
    chk("wr_count1", u[1].wr_cnt - w1, n);
    chk("rd_count0", u[0].rd_cnt - r0, n);
    chk("rd_count1", u[1].rd_cnt - r1, n);
    chk("busy_cyc0", u[0].busy_cnt - b0, (n == 0) ? 0 : lat0 - 1);
    chk("busy_cyc1", u[1].busy_cnt - b1, (n == 0) ? 0 : lat1 - 1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errc0", 32'(errc[0]), 32'd0);
    chk("rst_errc1", 32'(errc[1]), 32'd0);
    chk("rst_eseen", 32'(eseen), 32'd0);
    chk("rst_ferr0", ferr[0], 32'd0);
    chk("rst_read", 32'(u[0].bus.avm_read), 32'd0);
    chk("rst_write", 32'(u[0].bus.avm_write), 32'd0);
    chk("rst_addr", u[0].bus.avm_address, 32'd0);
    chk("rst_wdata", u[0].bus.avm_writedata, 32'd0);
    chk("rst_be", 32'(u[0].bus.avm_byteenable), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait baseline: 8 writes back to back, 8 reads, clean
    launch(32'h0, 13'd8, 32'h0);
    finish(8, 25, 41);
    chk("t1_wr_last0", u[0].wr_last - s_cyc, 8);
    chk("t1_errc0", 32'(errc[0]), 32'd0);
    chk("t1_errc1", 32'(errc[1]), 32'd0);
    chk("t1_eseen", 32'(eseen), 32'd0);

    // Stall 3 cycles on write word 2 and read word 5
    wr_stall = 2;
    rd_stall = 5;
    launch(32'h40, 13'd8, 32'hCAFEF00D);
    finish(8, 31, 47);
    chk("t2_errc0", 32'(errc[0]), 32'd0);
    chk("t2_errc1", 32'(errc[1]), 32'd0);
    wr_stall = -1;
    rd_stall = -1;

    // Word 3 corrupted on read-back
    corrupt_word = 3;
    launch(32'h100, 13'd8, 32'h12345678);
    finish(8, 25, 41);
    chk("t3_errc0", 32'(errc[0]), 32'd1);
    chk("t3_errc1", 32'(errc[1]), 32'd1);
    chk("t3_ferr0", ferr[0], 32'h10C);
    chk("t3_ferr1", ferr[1], 32'h10C);
    chk("t3_eseen", 32'(eseen), 32'd3);
    corrupt_word = -1;

    // Empty run: no bus activity, done one cycle after start, results cleared
    launch(32'h300, 13'd0, 32'h5555AAAA);
    finish(0, 1, 1);
    chk("t4_errc0", 32'(errc[0]), 32'd0);
    chk("t4_eseen", 32'(eseen), 32'd0);
    chk("t4_ferr0", ferr[0], 32'd0);

    // Reset while the latency-1 master waits on read word 2
    corrupt_word = 0;
    launch(32'h80, 13'd8, 32'h0BADCAFE);
    repeat (13) @(negedge clk);
    chk("t5_pre_errc0", 32'(errc[0]), 32'd1);
    chk("t5_pre_errc1", 32'(errc[1]), 32'd1);
    chk("t5_pre_ferr0", ferr[0], 32'h80);
    chk("t5_pre_busy", 32'(busy), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_read0", 32'(u[0].bus.avm_read), 32'd0);
    chk("t5_read1", 32'(u[1].bus.avm_read), 32'd0);
    chk("t5_write1", 32'(u[1].bus.avm_write), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_errc0", 32'(errc[0]), 32'd0);
    chk("t5_errc1", 32'(errc[1]), 32'd0);
    chk("t5_eseen", 32'(eseen), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_nodone0", u[0].done_cnt - d0, 0);
    chk("t5_nodone1", u[1].done_cnt - d1, 0);
    corrupt_word = -1;
    launch(32'h80, 13'd8, 32'h0BADCAFE);
    finish(8, 25, 41);
    chk("t5_rerun_errc0", 32'(errc[0]), 32'd0);
    chk("t5_rerun_errc1", 32'(errc[1]), 32'd0);

    // Start while busy is ignored; unaligned base is rounded down
    launch(32'h203, 13'd8, 32'h77770001);
    repeat (4) @(negedge clk);
    pulse_ignored_start(32'h600, 13'd3, 32'h88887777);
    finish(8, 25, 41);
    chk("t6_errc0", 32'(errc[0]), 32'd0);
    chk("t6_errc1", 32'(errc[1]), 32'd0);

    // Start in FIN (latency-1 master) is dropped
    launch(32'h20, 13'd4, 32'h13579BDF);
    repeat (12) @(negedge clk);
    pulse_ignored_start(32'h20, 13'd4, 32'h13579BDF);
    finish(4, 13, 21);
    repeat (10) @(negedge clk);
    chk("t7_wr_total0", u[0].wr_cnt - w0, 4);
    chk("t7_wr_total1", u[1].wr_cnt - w1, 4);
    chk("t7_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
